// File: rtl/tdm_mux_sequencer_pkg.sv
// Shared types and constants for the 4-channel TDM mux/demux sequencer.
package tdm_pkg;

    localparam int NCH   = 4;
    localparam int SEL_W = 2;

    localparam logic [SEL_W-1:0] SEL_LAST = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [NCH-1:0]   ch_t;

endpackage

// File: rtl/tdm_mux_sequencer_if.sv
// Control, channel and status bundle between the sequencer and its environment.
interface tdm_mux_sequencer_if;
    import tdm_pkg::*;

    logic start;
    logic stop;
    logic mode;
    ch_t  d_in;
    logic mux_y;
    sel_t sel;
    ch_t  ch_out;
    logic slot_strobe;
    logic frame_done;
    logic busy;
    logic err;

    modport master (
        output start, stop, mode, d_in, mux_y,
        input  sel, ch_out, slot_strobe, frame_done, busy, err
    );

    modport slave (
        input  start, stop, mode, d_in, mux_y,
        output sel, ch_out, slot_strobe, frame_done, busy, err
    );

endinterface

// File: rtl/tdm_mux_sequencer_slot_timer.sv
// Dwell counter: counts 0..SLOT_CYCLES-1 while enabled and flags the final cycle of a slot.
module slot_timer #(
    parameter int SLOT_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam logic [CNT_W-1:0] LAST_V = CNT_W'(SLOT_CYCLES - 1);

    logic [CNT_W-1:0] dwell;

    assign last = (dwell == LAST_V);

    // Wraps on its own at the slot end, so the top never needs to clear it mid-run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell <= '0;
        end else if (clr) begin
            dwell <= '0;
        end else if (en) begin
            dwell <= last ? '0 : dwell + CNT_W'(1);
        end
    end

endmodule

// File: rtl/tdm_mux_sequencer.sv
// Drives the shared mux/demux select, samples mux_y at each slot end into ch_out and
// flags any sample that disagrees with the channel input.
module tdm_mux_sequencer
    import tdm_pkg::*;
#(
    parameter int SLOT_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic                clk,
    input  logic                rst,
    tdm_mux_sequencer_if.slave  bus
);

    state_e state, state_nxt;

    sel_t   sel_q, sel_nxt;
    ch_t    ch_q, ch_nxt;
    logic   stop_pend, stop_pend_nxt;
    logic   err_q, err_nxt;
    logic   strobe_q, done_q;

    logic   last;
    logic   sample;
    logic   frame_end;
    logic   halt;

    slot_timer #(
        .SLOT_CYCLES (SLOT_CYCLES),
        .CNT_W       (CNT_W)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == IDLE),
        .en   (state == RUN),
        .last (last)
    );

    assign sample    = (state == RUN) && last;
    assign frame_end = sample && (sel_q == SEL_LAST);
    assign halt      = frame_end && (stop_pend || bus.mode);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (halt)      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sel_nxt       = sel_q;
        stop_pend_nxt = stop_pend;
        err_nxt       = err_q;
        case (state)
            IDLE: begin
                sel_nxt = '0;
                if (bus.start) begin
                    stop_pend_nxt = bus.stop || bus.mode;
                    err_nxt       = 1'b0;
                end
            end
            RUN: begin
                if (bus.stop) stop_pend_nxt = 1'b1;
                if (sample) begin
                    if (bus.mux_y != bus.d_in[sel_q]) err_nxt = 1'b1;
                    sel_nxt = frame_end ? '0 : sel_q + 1'b1;
                end
                if (halt) stop_pend_nxt = 1'b0;
            end
            default: sel_nxt = '0;
        endcase
    end

    // Only the channel currently selected captures mux_y; the others hold.
    for (genvar k = 0; k < NCH; k++) begin : g_ch
        assign ch_nxt[k] = (sample && (sel_q == SEL_W'(k))) ? bus.mux_y : ch_q[k];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q     <= '0;
            ch_q      <= '0;
            stop_pend <= 1'b0;
            err_q     <= 1'b0;
            strobe_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            sel_q     <= sel_nxt;
            ch_q      <= ch_nxt;
            stop_pend <= stop_pend_nxt;
            err_q     <= err_nxt;
            strobe_q  <= sample;
            done_q    <= frame_end;
        end
    end

    assign bus.sel         = sel_q;
    assign bus.ch_out      = ch_q;
    assign bus.slot_strobe = strobe_q;
    assign bus.frame_done  = done_q;
    assign bus.busy        = (state == RUN);
    assign bus.err         = err_q;

endmodule

// File: tb/tb_tdm_mux_sequencer.sv
// Bench for tdm_mux_sequencer: SLOT_CYCLES=4 and SLOT_CYCLES=1 instances against a slot-arithmetic model.
module tb_tdm_mux_sequencer;
    import tdm_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       start4 = 1'b0, start1 = 1'b0, stop = 1'b0, mode = 1'b0;
    logic [3:0] d = 4'h0;
    logic       kill_en = 1'b0;
    logic [1:0] kill_sel = 2'd0;
    logic       mon = 1'b0;

    int checks = 0;
    int errors = 0;

    tdm_mux_sequencer_if bus4();
    tdm_mux_sequencer_if bus1();

    assign bus4.start = start4;
    assign bus4.stop  = stop;
    assign bus4.mode  = mode;
    assign bus4.d_in  = d;
    assign bus4.mux_y = (kill_en && bus4.sel == kill_sel) ? 1'b0 : bus4.d_in[bus4.sel];
    assign bus1.start = start1;
    assign bus1.stop  = stop;
    assign bus1.mode  = mode;
    assign bus1.d_in  = d;
    assign bus1.mux_y = (kill_en && bus1.sel == kill_sel) ? 1'b0 : bus1.d_in[bus1.sel];

    tdm_mux_sequencer #(.SLOT_CYCLES(4), .CNT_W(8)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    tdm_mux_sequencer #(.SLOT_CYCLES(1), .CNT_W(8)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: t = cycles elapsed since the run began; slot and sample point follow from t and S.
    typedef struct packed {
        logic        run;
        logic [15:0] t;
        logic        pend;
        logic [3:0]  ch;
        logic        err;
        logic        strobe;
        logic        done;
    } ms_t;

    ms_t m4 = '0;
    ms_t m1 = '0;

    function automatic ms_t step(ms_t s, logic st, logic sp, logic md, logic [3:0] dv, logic y, int S);
        ms_t n;
        int  slot;
        n = s;
        n.strobe = 1'b0;
        n.done   = 1'b0;
        if (!s.run) begin
            if (st) begin
                n.run = 1'b1; n.t = '0; n.err = 1'b0; n.pend = sp | md;
            end
        end else begin
            slot = (int'(s.t) / S) % 4;
            if (int'(s.t) % S == S - 1) begin
                n.strobe   = 1'b1;
                n.ch[slot] = y;
                if (y !== dv[slot]) n.err = 1'b1;
                n.done = (slot == 3);
            end
            if (sp) n.pend = 1'b1;
            if (n.done && (s.pend || md)) begin
                n.run = 1'b0; n.pend = 1'b0; n.t = '0;
            end else begin
                n.t = 16'((int'(s.t) + 1) % (4 * S));
            end
        end
        return n;
    endfunction

    function automatic logic [9:0] mexp(ms_t s, int S);
        logic [1:0] sl;
        sl = s.run ? 2'((int'(s.t) / S) % 4) : 2'd0;
        return {sl, s.ch, s.strobe, s.done, s.run, s.err};
    endfunction

    function automatic logic [9:0] pack4();
        return {bus4.sel, bus4.ch_out, bus4.slot_strobe, bus4.frame_done, bus4.busy, bus4.err};
    endfunction

    function automatic logic [9:0] pack1();
        return {bus1.sel, bus1.ch_out, bus1.slot_strobe, bus1.frame_done, bus1.busy, bus1.err};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m4 = '0;
            m1 = '0;
        end else begin
            m4 = step(m4, start4, stop, mode, d, bus4.mux_y, 4);
            m1 = step(m1, start1, stop, mode, d, bus1.mux_y, 1);
        end
    end

    always @(negedge clk) begin
        if (mon) begin
            chk("model4", 32'(pack4()), 32'(mexp(m4, 4)));
            chk("model1", 32'(pack1()), 32'(mexp(m1, 1)));
        end
    end

    typedef struct {
        logic       mode;
        int         stop_cyc;
        logic [3:0] d;
        int         kill;
        logic [3:0] exp_ch;
        logic       exp_err;
        int         exp_frames;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v, input int idx);
        int cyc, frames, first, strobes;
        logic fin;
        @(negedge clk);
        d = v.d; mode = v.mode; kill_en = (v.kill >= 0); kill_sel = 2'(v.kill);
        start4 = 1'b1; stop = (v.stop_cyc == 0);
        cyc = 0; frames = 0; first = -1; strobes = 0; fin = 1'b0;
        while (!fin && cyc < 200) begin
            @(negedge clk);
            start4 = 1'b0;
            cyc++;
            stop = (cyc == v.stop_cyc);
            if (bus4.slot_strobe) strobes++;
            if (bus4.frame_done) begin
                frames++;
                if (first < 0) first = cyc;
            end
            if (!bus4.busy) fin = 1'b1;
        end
        stop = 1'b0; kill_en = 1'b0;
        chk($sformatf("vec%0d_finished", idx), 32'(fin), 32'd1);
        chk($sformatf("vec%0d_frames", idx), 32'(frames), 32'(v.exp_frames));
        chk($sformatf("vec%0d_first_done", idx), 32'(first), 32'd17);
        chk($sformatf("vec%0d_strobes", idx), 32'(strobes), 32'(4 * v.exp_frames));
        chk($sformatf("vec%0d_ch_out", idx), 32'(bus4.ch_out), 32'(v.exp_ch));
        chk($sformatf("vec%0d_err", idx), 32'(bus4.err), 32'(v.exp_err));
        repeat (3) @(negedge clk);
        chk($sformatf("vec%0d_err_held", idx), 32'(bus4.err), 32'(v.exp_err));
        chk($sformatf("vec%0d_idle", idx), 32'({bus4.busy, bus4.sel}), 32'd0);
    endtask

    initial begin
        int   cyc, f1, f2;
        logic gap, fin;

        vecs[0] = '{1'b1, -1, 4'b1010, -1, 4'b1010, 1'b0, 1};
        vecs[1] = '{1'b1, -1, 4'b1111,  2, 4'b1011, 1'b1, 1};
        vecs[2] = '{1'b1, -1, 4'b0000, -1, 4'b0000, 1'b0, 1};
        vecs[3] = '{1'b1, -1, 4'b0101,  0, 4'b0100, 1'b1, 1};
        vecs[4] = '{1'b0,  6, 4'b1100, -1, 4'b1100, 1'b0, 1};
        vecs[5] = '{1'b0,  0, 4'b0011,  1, 4'b0001, 1'b1, 1};

        #1 rst = 1'b1;
        mon = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_state4", 32'(pack4()), 32'd0);
        chk("reset_state1", 32'(pack1()), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Continuous frames, channel data changed between frames.
        @(negedge clk);
        d = 4'h5; mode = 1'b0; start4 = 1'b1;
        cyc = 0; f1 = -1; f2 = -1; gap = 1'b0;
        while (f2 < 0 && cyc < 100) begin
            @(negedge clk);
            start4 = 1'b0;
            cyc++;
            if (!bus4.busy) gap = 1'b1;
            if (bus4.frame_done) begin
                if (f1 < 0) begin
                    f1 = cyc;
                    chk("b2b_ch_frame1", 32'(bus4.ch_out), 32'h5);
                    d = 4'hA;
                end else begin
                    f2 = cyc;
                    chk("b2b_ch_frame2", 32'(bus4.ch_out), 32'hA);
                end
            end
        end
        chk("b2b_first_done", 32'(f1), 32'd17);
        chk("b2b_period", 32'(f2 - f1), 32'd16);
        chk("b2b_no_gap", 32'(gap), 32'd0);
        @(negedge clk) stop = 1'b1;
        @(negedge clk) stop = 1'b0;
        cyc = 0; fin = 1'b0;
        while (!fin && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (!bus4.busy) fin = 1'b1;
        end
        chk("b2b_stopped", 32'(fin), 32'd1);
        chk("b2b_final", 32'({bus4.sel, bus4.ch_out}), 32'({2'd0, 4'hA}));

        // Async reset in slot 1, dwell 2.
        @(negedge clk);
        mode = 1'b1; d = 4'hF; start4 = 1'b1;
        @(negedge clk) start4 = 1'b0;
        repeat (6) @(negedge clk);
        chk("rst_pre_sel", 32'(bus4.sel), 32'd1);
        #2 rst = 1'b1;
        #1 chk("rst_async4", 32'(pack4()), 32'd0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk) start4 = 1'b1;
        @(negedge clk) start4 = 1'b0;
        chk("rst_restart", 32'({bus4.busy, bus4.sel}), 32'({1'b1, 2'd0}));
        cyc = 0; fin = 1'b0;
        while (!fin && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (!bus4.busy) fin = 1'b1;
        end
        chk("rst_frame_done", 32'(fin), 32'd1);
        chk("rst_frame_ch", 32'({bus4.ch_out, bus4.err}), 32'({4'hF, 1'b0}));

        // SLOT_CYCLES=1: start+stop together, then a start issued mid-run.
        @(negedge clk);
        start1 = 1'b1; stop = 1'b1; mode = 1'b0; d = 4'h6;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start1 = (c == 2);
            stop = 1'b0;
            chk($sformatf("s1_cyc%0d", c), 32'({bus1.busy, bus1.sel}), 32'({1'b1, 2'(c - 1)}));
        end
        @(negedge clk);
        start1 = 1'b0;
        chk("s1_end", 32'({bus1.busy, bus1.frame_done, bus1.ch_out}), 32'({1'b0, 1'b1, 4'h6}));
        @(negedge clk);
        chk("s1_no_restart", 32'({bus1.busy, bus1.frame_done}), 32'd0);

        // Randomized traffic on both instances; the per-cycle model check does the work.
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            start4   = ($urandom_range(0, 7) == 0);
            start1   = ($urandom_range(0, 7) == 0);
            stop     = ($urandom_range(0, 15) == 0);
            mode     = 1'($urandom_range(0, 1));
            d        = 4'($urandom);
            kill_en  = ($urandom_range(0, 3) == 0);
            kill_sel = 2'($urandom_range(0, 3));
        end
        @(negedge clk);
        start4 = 1'b0; start1 = 1'b0; kill_en = 1'b0; stop = 1'b1;
        cyc = 0; fin = 1'b0;
        while (!fin && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (!bus4.busy && !bus1.busy) fin = 1'b1;
        end
        stop = 1'b0;
        chk("random_drain", 32'(fin), 32'd1);

        @(negedge clk);
        mon = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
